// File: rtl/a_sram_reader.sv
// a_sram_reader: reads an int8 matrix back out of the 16-bank A SRAM and streams it as 32-byte half-rows.
// Optional macro A_SRAM_READER_PADCHK_EN adds a sticky o_pad_err flag for nonzero word padding.
`default_nettype none

module a_sram_reader #(
    parameter  int MATRIX_SIZE = 64,
    parameter  int LANE_NUM    = 16,
    parameter  int WORD_W      = 264,
    parameter  int RD_LAT      = 1,
    localparam int HALVES      = MATRIX_SIZE / 32,
    localparam int NUM_ADDR    = MATRIX_SIZE * HALVES / LANE_NUM,
    localparam int AW          = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1,
    localparam int RW          = $clog2(MATRIX_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_rd_en,
    output logic [AW-1:0]              o_rd_addr,
    input  logic [LANE_NUM*WORD_W-1:0] i_rd_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [255:0]               o_out_data,
    output logic [RW-1:0]              o_out_row,
    output logic [RW-1:0]              o_out_col,
`ifdef A_SRAM_READER_PADCHK_EN
    output logic                       o_pad_err,
`endif
    output logic                       o_out_last
);

    localparam int LW   = (LANE_NUM > 1) ? $clog2(LANE_NUM) : 1;
    localparam int WTW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int PADW = WORD_W - 256;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WAIT   = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } t_state;

    t_state          r_state;
    logic [AW-1:0]   r_cnt;
    logic [LW-1:0]   r_idx;
    logic [WTW-1:0]  r_wait;
    logic [255:0]    r_lane [LANE_NUM];

    logic [255:0]    w_word [LANE_NUM];
    logic [PADW-1:0] w_pad  [LANE_NUM];
    logic            w_pad_any;
    logic            w_last_addr;
    logic [LW-1:0]   w_idx_nxt;

    generate
        for (genvar gl = 0; gl < LANE_NUM; gl++) begin : g_lane
            assign w_word[gl] = i_rd_data[gl*WORD_W +: 256];
            assign w_pad[gl]  = i_rd_data[gl*WORD_W + 256 +: PADW];
        end
    endgenerate

    always_comb begin
        w_pad_any = 1'b0;
        for (int l = 0; l < LANE_NUM; l++) begin
            w_pad_any = w_pad_any | (|w_pad[l]);
        end
    end

`ifndef A_SRAM_READER_PADCHK_EN
    logic w_unused_pad;
    assign w_unused_pad = w_pad_any;
`endif

    assign w_last_addr = (r_cnt == AW'(NUM_ADDR - 1));
    assign w_idx_nxt   = r_idx + 1'b1;
    assign o_rd_addr   = r_cnt;

    // SRAM stores the half-row with column 0 in the top byte; flip to natural order.
    function automatic logic [255:0] f_unpack(input logic [255:0] w);
        logic [255:0] o;
        for (int k = 0; k < 32; k++) begin
            o[8*k +: 8] = w[8*(31-k) +: 8];
        end
        return o;
    endfunction

    function automatic logic [RW-1:0] f_row(input logic [AW-1:0] a, input logic [LW-1:0] l);
        int r;
        r = (int'(a) / HALVES) * LANE_NUM + int'(l);
        return r[RW-1:0];
    endfunction

    function automatic logic [RW-1:0] f_col(input logic [AW-1:0] a);
        int c;
        c = (int'(a) % HALVES) * 32;
        return c[RW-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_wait      <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_rd_en     <= 1'b0;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_out_row   <= '0;
            o_out_col   <= '0;
            o_out_last  <= 1'b0;
`ifdef A_SRAM_READER_PADCHK_EN
            o_pad_err   <= 1'b0;
`endif
            for (int l = 0; l < LANE_NUM; l++) begin
                r_lane[l] <= '0;
            end
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_READ;
                        r_cnt   <= '0;
                        o_busy  <= 1'b1;
                        o_rd_en <= 1'b1;
`ifdef A_SRAM_READER_PADCHK_EN
                        o_pad_err <= 1'b0;
`endif
                    end
                end
                S_READ: begin
                    o_rd_en <= 1'b0;
                    r_wait  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == WTW'(RD_LAT - 1)) begin
                        for (int l = 0; l < LANE_NUM; l++) begin
                            r_lane[l] <= f_unpack(w_word[l]);
                        end
`ifdef A_SRAM_READER_PADCHK_EN
                        o_pad_err <= o_pad_err | w_pad_any;
`endif
                        r_idx       <= '0;
                        o_out_valid <= 1'b1;
                        o_out_data  <= f_unpack(w_word[0]);
                        o_out_row   <= f_row(r_cnt, '0);
                        o_out_col   <= f_col(r_cnt);
                        o_out_last  <= w_last_addr && (LANE_NUM == 1);
                        r_state     <= S_STREAM;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_STREAM: begin
                    if (i_out_ready) begin
                        if (r_idx == LW'(LANE_NUM - 1)) begin
                            o_out_valid <= 1'b0;
                            o_out_last  <= 1'b0;
                            if (w_last_addr) begin
                                o_busy  <= 1'b0;
                                o_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_cnt   <= r_cnt + 1'b1;
                                o_rd_en <= 1'b1;
                                r_state <= S_READ;
                            end
                        end else begin
                            r_idx      <= w_idx_nxt;
                            o_out_data <= r_lane[w_idx_nxt];
                            o_out_row  <= f_row(r_cnt, w_idx_nxt);
                            o_out_last <= w_last_addr && (w_idx_nxt == LW'(LANE_NUM - 1));
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_a_sram_reader.sv
// tb_a_sram_reader: scoreboard bench for a_sram_reader against a behavioural SRAM in the writer's format.
`default_nettype none

module tb_a_sram_reader;

    localparam int P_RD_LAT = 1;
    localparam int MS       = 64;
    localparam int LN       = 16;
    localparam int WW       = 264;
    localparam int HALVES   = MS / 32;
    localparam int NA       = MS * HALVES / LN;
    localparam int PAD_A    = 3;
    localparam int PAD_L    = 5;

    typedef logic [268:0] t_beat;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0;
    logic              i_out_ready;
    logic              o_busy, o_done, o_rd_en, o_out_valid, o_out_last;
    logic [2:0]        o_rd_addr;
    logic [LN*WW-1:0]  i_rd_data;
    logic [255:0]      o_out_data;
    logic [5:0]        o_out_row, o_out_col;
`ifdef A_SRAM_READER_PADCHK_EN
    logic              o_pad_err;
`endif

    a_sram_reader #(
        .MATRIX_SIZE (MS),
        .LANE_NUM    (LN),
        .WORD_W      (WW),
        .RD_LAT      (P_RD_LAT)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rd_en     (o_rd_en),
        .o_rd_addr   (o_rd_addr),
        .i_rd_data   (i_rd_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_row   (o_out_row),
        .o_out_col   (o_out_col),
`ifdef A_SRAM_READER_PADCHK_EN
        .o_pad_err   (o_pad_err),
`endif
        .o_out_last  (o_out_last)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_beats = 0;
    int          n_done = 0;
    int          n_rden = 0;
    int          start_cyc = 0;
    int          first_valid_cyc = -1;
    int          last_hs_cyc = -1;
    int          done_cyc = -1;
    int          rdy_mode = 0;
    logic [7:0]  pad_v = 8'h00;
    t_beat       q[$];
    logic [LN*WW-1:0] sram_pipe [P_RD_LAT];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input t_beat obs, input t_beat exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected beat for address a, lane l with matrix[i][j] = (i+j) % 256.
    function automatic t_beat f_beat(input int a, input int l);
        logic [255:0] d;
        int row, col;
        row = (a / HALVES) * LN + l;
        col = (a % HALVES) * 32;
        for (int k = 0; k < 32; k++) d[8*k +: 8] = 8'((row + col + k) % 256);
        return {(a == NA-1 && l == LN-1), 6'(row), 6'(col), d};
    endfunction

    function automatic logic [LN*WW-1:0] f_sram(input int a);
        logic [LN*WW-1:0] w;
        int row, col;
        w = '0;
        for (int l = 0; l < LN; l++) begin
            row = (a / HALVES) * LN + l;
            col = (a % HALVES) * 32;
            for (int k = 0; k < 32; k++) w[l*WW + 8*(31-k) +: 8] = 8'((row + col + k) % 256);
            if (a == PAD_A && l == PAD_L) w[l*WW + 256 +: 8] = pad_v;
        end
        return w;
    endfunction

    initial begin
        for (int i = 0; i < P_RD_LAT; i++) sram_pipe[i] = '0;
    end

    always @(posedge clk) begin
        if (o_rd_en) sram_pipe[0] <= f_sram(int'(o_rd_addr));
        for (int i = 1; i < P_RD_LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
    end
    assign i_rd_data = sram_pipe[P_RD_LAT-1];

    initial begin
        i_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) i_out_ready = ($urandom_range(0, 9) < 3);
            else               i_out_ready = 1'b1;
        end
    end

    // Compare every presented beat against the queue head; pop only on handshake.
    always @(negedge clk) begin
        if (!rst && o_out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (q.size() == 0) begin
                if (i_out_ready) check("extra_beat", 1, 0);
            end else begin
                check($sformatf("beat%0d", n_beats), {o_out_last, o_out_row, o_out_col, o_out_data}, q[0]);
                if (i_out_ready) begin
                    void'(q.pop_front());
                    n_beats++;
                    if (o_out_last) last_hs_cyc = cyc;
                end
            end
        end
        if (!rst && o_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (!rst && o_rd_en) n_rden++;
    end

    task automatic clear_counts();
        n_beats = 0; n_done = 0; n_rden = 0; last_hs_cyc = -1; done_cyc = -1;
    endtask

    task automatic push_matrix();
        for (int a = 0; a < NA; a++)
            for (int l = 0; l < LN; l++) q.push_back(f_beat(a, l));
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start_cyc = cyc;
        first_valid_cyc = -1;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (n_done == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n_done == 0) check("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n;
        n = 0;
        while (n_beats < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n_beats < target) check("beat_timeout", t_beat'(n_beats), t_beat'(target));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", {o_busy, o_done, o_rd_en, o_out_valid, o_out_last}, 0);
        check("rst_addr", o_rd_addr, 0);
        check("rst_tags", {o_out_row, o_out_col}, 0);
        check("rst_data", o_out_data, 0);
        rst = 1'b0;

        // Straight readback with ready held high.
        clear_counts();
        push_matrix();
        pulse_start();
        check("busy_after_start", o_busy, 1);
        wait_done(2000);
        check("first_valid_lat", t_beat'(first_valid_cyc - start_cyc), t_beat'(2 + P_RD_LAT));
        check("last_hs_lat", t_beat'(last_hs_cyc - start_cyc), t_beat'(NA * (1 + P_RD_LAT + LN)));
        check("done_after_last", t_beat'(done_cyc - last_hs_cyc), 1);
        check("t1_beats", t_beat'(n_beats), 128);
        check("t1_done_cnt", t_beat'(n_done), 1);
        check("t1_rden_cnt", t_beat'(n_rden), t_beat'(NA));
        check("t1_left", t_beat'(q.size()), 0);
        check("t1_busy_end", o_busy, 0);

        // Random backpressure.
        clear_counts();
        rdy_mode = 1;
        push_matrix();
        pulse_start();
        wait_done(6000);
        rdy_mode = 0;
        check("bp_beats", t_beat'(n_beats), 128);
        check("bp_done_cnt", t_beat'(n_done), 1);
        check("bp_rden_cnt", t_beat'(n_rden), t_beat'(NA));
        check("bp_left", t_beat'(q.size()), 0);

        // Start while busy is ignored, then reset mid-stream.
        clear_counts();
        push_matrix();
        pulse_start();
        wait_beats(20, 500);
        @(posedge clk); #1; i_start = 1'b1;
        @(posedge clk); #1; i_start = 1'b0;
        check("busy_restart_ign", o_busy, 1);
        wait_beats(40, 500);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", o_out_valid, 0);
        check("rst_mid_busy", o_busy, 0);
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_no_done", t_beat'(n_done), 0);
        check("rst_mid_rden", t_beat'(n_rden), 3);
        clear_counts();
        push_matrix();
        pulse_start();
        wait_done(2000);
        check("fresh_beats", t_beat'(n_beats), 128);
        check("fresh_done_cnt", t_beat'(n_done), 1);
        check("fresh_left", t_beat'(q.size()), 0);

`ifdef A_SRAM_READER_PADCHK_EN
        // Nonzero padding on one lane word raises the sticky flag.
        clear_counts();
        pad_v = 8'h01;
        push_matrix();
        pulse_start();
        check("pad_clear_start", o_pad_err, 0);
        wait_beats(40, 500);
        check("pad_before_cap", o_pad_err, 0);
        wait_beats(PAD_A * LN + 1, 500);
        check("pad_after_cap", o_pad_err, 1);
        wait_done(2000);
        check("pad_through_done", o_pad_err, 1);
        pad_v = 8'h00;
        clear_counts();
        push_matrix();
        pulse_start();
        check("pad_cleared", o_pad_err, 0);
        wait_done(2000);
        check("pad_clean_run", o_pad_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire

// File: doc/a_sram_reader.md
Name: a_sram_reader

Overview:
- Read-side counterpart of the A-matrix SRAM writer. Fetches a MATRIX_SIZE x MATRIX_SIZE int8 matrix back out of the 16-bank A SRAM.
- Unpacks each 264-bit lane word into a 32-byte half-row in natural column order.
- Streams half-rows to downstream compute over a valid/ready interface, with row/column tags and a last flag.

Parameters:
- MATRIX_SIZE, 64, matrix dimension (must be a multiple of 32).
- LANE_NUM, 16, number of SRAM banks/lanes read in parallel.
- WORD_W, 264, SRAM word width; bits [255:0] carry data, [263:256] are padding.
- RD_LAT, 1, SRAM read latency in cycles from rd_en to valid rd_data (>=1).
- Derived, not overridable: HALVES = MATRIX_SIZE/32; NUM_ADDR = MATRIX_SIZE*HALVES/LANE_NUM (8 at defaults); AW = clog2(NUM_ADDR).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  begin a full-matrix read; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the final output handshake.
- rd_en  output  1  read strobe to all banks.
- rd_addr  output  AW  common read address to all banks.
- rd_data  input  LANE_NUM*WORD_W  concatenated bank outputs; lane L occupies [L*WORD_W +: WORD_W].
- out_valid  output  1  out_data and its tags are valid.
- out_ready  input  1  downstream accept.
- out_data  output  256  half-row; byte k [8k+7:8k] = matrix[out_row][out_col+k].
- out_row  output  clog2(MATRIX_SIZE)  row index of the current beat.
- out_col  output  clog2(MATRIX_SIZE)  starting column of the beat (multiple of 32).
- out_last  output  1  high on the final beat of the matrix.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, rd_en, out_valid, out_last = 0; rd_addr, out_data, out_row, out_col = 0; lane buffer cleared.
- Address mapping for address a, lane L: row = (a/HALVES)*LANE_NUM + L; col = (a%HALVES)*32.
- Unpack: out_data byte k = rd_data lane word byte (31-k), i.e. byte order is reversed relative to SRAM storage.
- IDLE: when start=1, go to READ with address counter = 0 and busy=1.
- READ: one cycle with rd_en=1 and rd_addr=counter, then go to WAIT.
- WAIT: RD_LAT cycles. On the final WAIT edge, capture all LANE_NUM words (bits [255:0]) into the lane buffer, then go to STREAM with lane index = 0.
- STREAM:
  - out_valid=1 and presents lane[lane index].
  - On out_valid&&out_ready, advance the lane index.
  - After lane LANE_NUM-1 is accepted: if counter==NUM_ADDR-1, go to DONE; otherwise increment the counter and go to READ.
  - While out_ready=0, out_data, out_row, out_col and out_last hold stable and out_valid stays high; no SRAM read is issued.
- DONE: done=1 for one cycle, busy=0, then IDLE. A start in the DONE cycle is ignored.
- start while busy: ignored; the stream is not restarted.
- out_last=1 only on lane LANE_NUM-1 of address NUM_ADDR-1.
- rd_en is never high outside READ. There is exactly one rd_en pulse per address, NUM_ADDR pulses per matrix.
- Latency with out_ready held at 1: the first out_valid rises 2+RD_LAT cycles after the start edge. Each address costs 1+RD_LAT+LANE_NUM cycles, which is 144 cycles total at defaults.
- Reset mid-STREAM: the beat is dropped, no done pulse, outputs return to their reset values immediately.

Optional Feature:
- Macro A_SRAM_READER_PADCHK_EN.
- When defined:
  - Adds output pad_err (1 bit, reset 0).
  - pad_err is set sticky if any captured lane word has nonzero bits [263:256].
  - pad_err is cleared only by rst or by an accepted start.
- When undefined: the pad_err port does not exist and bits [263:256] are ignored.

Test Plan:
- Basic readback:
  - Stimulus: SRAM model preloaded with the writer's format for matrix[i][j]=(i+j)%256, out_ready=1, pulse start.
  - Required: beat 0 has row=0, col=0, out_data=0x1F1E...0100. Beat 1 has row=1, col=0, out_data=0x201F...0201.
  - Required: the final beat has row=63, col=32, data bytes 0x5F..0x7E, and out_last=1.
  - Required: done pulses exactly once, 1 cycle after the final handshake; total 128 beats.
- Ordering: log all 128 beats -> (row, col) sequence follows a=0..7, L=0..15 with row=(a/2)*16+L, col=(a%2)*32. Every byte matches (row+col+k)%256.
- Backpressure:
  - Stimulus: out_ready random at 30% duty.
  - Required: out_data and tags stable while stalled, no dropped or duplicate beats, rd_en pulses == 8.
- RD_LAT=3 build: capture aligns to a model with a 3-cycle latency; the first out_valid rises 5 cycles after the start edge.
- Start while busy, then reset mid-stream:
  - Stimulus: start re-pulsed at beat 20 -> ignored, sequence unchanged.
  - Stimulus: rst asserted at beat 40 -> out_valid=0 and busy=0 immediately, no done pulse.
  - Required: a fresh start restarts from row 0.
- Pad check (macro defined):
  - Stimulus: a lane-5 word at address 3 with bits [263:256]=0x01.
  - Required: pad_err rises after that capture, stays 1 through done, and clears on the next accepted start.
